// File: rtl/frac_tcam_pkg.sv
// ============================================================================
// Module      : frac_tcam_pkg
// Description : Shared types and helpers for the fractured TCAM controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package frac_tcam_pkg;

  localparam int KW          = 5;
  localparam int SLICE_ADDRS = 32;
  localparam int GROUP_ROWS  = 8;

  typedef enum logic [1:0] {
    INIT  = 2'd0,
    IDLE  = 2'd1,
    DRAIN = 2'd2,
    WRITE = 2'd3
  } state_t;

  // One rule entry as seen by a single 5-bit slice of the array.
  typedef struct packed {
    logic          valid;
    logic [KW-1:0] value;
    logic [KW-1:0] mask;
  } slice_rule_t;

  // A slice LUT entry at addr matches when every cared-for bit agrees.
  function automatic logic slice_bit(input logic [KW-1:0] addr,
                                     input logic [KW-1:0] value5,
                                     input logic [KW-1:0] mask5);
    return ((addr ^ value5) & mask5) == '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/frac_tcam_ctrl_prio_enc.sv
// ============================================================================
// Module      : tcam_prio_enc
// Description : Registered lowest-index priority encoder for the match vector.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tcam_prio_enc #(
  parameter int D = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  input  logic [D-1:0]         match,
  output logic                 out_valid,
  output logic                 out_hit,
  output logic [$clog2(D)-1:0] out_index
);

  localparam int c_aw = $clog2(D);

  logic            w_hit;
  logic [c_aw-1:0] w_idx;

  always_comb begin
    w_hit = |match;
    w_idx = '0;
    for (int i = D - 1; i >= 0; i--) begin
      if (match[i]) w_idx = c_aw'(i);
    end
  end

  // Hit and index are forced to zero between results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_index <= '0;
    end else begin
      out_valid <= in_valid;
      out_hit   <= in_valid & w_hit;
      out_index <= in_valid ? w_idx : '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/frac_tcam_ctrl.sv
// ============================================================================
// Module      : frac_tcam_ctrl
// Description : Lookup/update sequencer for a fractured TCAM with shadow rules.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module frac_tcam_ctrl
  import frac_tcam_pkg::*;
#(
  parameter int W          = 20,
  parameter int D          = 64,
  parameter int LOOKUP_LAT = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  output logic                          init_done,
  input  logic                          lk_valid,
  output logic                          lk_ready,
  input  logic [W-1:0]                  lk_key,
  output logic                          res_valid,
  output logic                          res_hit,
  output logic [$clog2(D)-1:0]          res_index,
  input  logic                          upd_valid,
  output logic                          upd_ready,
  input  logic [$clog2(D)-1:0]          upd_row,
  input  logic                          upd_en,
  input  logic [W-1:0]                  upd_value,
  input  logic [W-1:0]                  upd_mask,
  output logic                          upd_done,
  output logic [W-1:0]                  tcam_sk,
  output logic [D/8-1:0]                tcam_we,
  output logic [(W/KW)*GROUP_ROWS-1:0]  tcam_rules,
  input  logic [D-1:0]                  tcam_match
);

  localparam int c_n  = W / KW;
  localparam int c_aw = $clog2(D);
  localparam int c_ng = D / GROUP_ROWS;
  localparam int c_gw = (c_ng > 1) ? $clog2(c_ng) : 1;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [KW-1:0]            r_cnt;
  logic [c_gw-1:0]          r_grp;
  logic                     r_last_upd;
  logic                     r_init_done;
  logic                     r_upd_done;
  logic [W-1:0]             r_lk_key;
  logic [LOOKUP_LAT:0]      r_lk_vld;
  logic [D-1:0]             r_sh_vld;
  logic [W-1:0]             r_sh_val [D];
  logic [W-1:0]             r_sh_msk [D];

  logic                     w_upd_grant;
  logic                     w_upd_fire;
  logic                     w_lk_fire;
  logic                     w_in_flight;
  logic                     w_sweep_end;
  logic [c_n*GROUP_ROWS-1:0] w_rules;

  assign w_sweep_end = (r_cnt == KW'(SLICE_ADDRS - 1));
  assign w_in_flight = |r_lk_vld;
  // Alternate after an update so a waiting lookup cannot be starved.
  assign w_upd_grant = upd_valid & ~(r_last_upd & lk_valid);
  assign w_upd_fire  = upd_valid & upd_ready;
  assign w_lk_fire   = lk_valid & lk_ready;

  // ---------------------------------------------------------------- state reg
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= INIT;
    else        r_state <= w_state_nxt;
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (w_sweep_end) w_state_nxt = IDLE;
      IDLE:    if (w_upd_fire) w_state_nxt = w_in_flight ? DRAIN : WRITE;
      DRAIN:   if (!w_in_flight) w_state_nxt = WRITE;
      WRITE:   if (w_sweep_end) w_state_nxt = IDLE;
      default: w_state_nxt = INIT;
    endcase
  end

  // ------------------------------------------------------------------ outputs
  // INIT drives all write enables, gated so reset itself leaves the array idle.
  always_comb begin
    lk_ready   = 1'b0;
    upd_ready  = 1'b0;
    tcam_we    = '0;
    tcam_rules = '0;
    tcam_sk    = r_lk_key;
    case (r_state)
      INIT: begin
        tcam_we = {c_ng{rst_n}};
        tcam_sk = {c_n{r_cnt}};
      end
      IDLE: begin
        upd_ready = w_upd_grant;
        lk_ready  = ~w_upd_grant;
      end
      WRITE: begin
        tcam_we    = c_ng'(1) << r_grp;
        tcam_rules = w_rules;
        tcam_sk    = {c_n{r_cnt}};
      end
      default: ;
    endcase
  end

  assign init_done = r_init_done;
  assign upd_done  = r_upd_done;

  // ----------------------------------------------------------------- datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_grp       <= '0;
      r_last_upd  <= 1'b0;
      r_init_done <= 1'b0;
      r_upd_done  <= 1'b0;
      r_lk_key    <= '0;
      r_lk_vld    <= '0;
    end else begin
      r_cnt      <= (r_state == INIT || r_state == WRITE) ? r_cnt + KW'(1) : '0;
      r_upd_done <= (r_state == WRITE) && w_sweep_end;
      if (r_state == INIT && w_sweep_end) r_init_done <= 1'b1;
      if (w_upd_fire) begin
        r_grp      <= c_gw'(upd_row >> 3);
        r_last_upd <= 1'b1;
      end else if (w_lk_fire) begin
        r_last_upd <= 1'b0;
      end
      if (w_lk_fire) r_lk_key <= lk_key;
      r_lk_vld[0] <= w_lk_fire;
      for (int k = 1; k <= LOOKUP_LAT; k++) r_lk_vld[k] <= r_lk_vld[k-1];
    end
  end

  // -------------------------------------------------------------- shadow rules
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_sh_vld          <= '0;
    else if (w_upd_fire) r_sh_vld[upd_row] <= upd_en;
  end

  always_ff @(posedge clk) begin
    if (w_upd_fire) begin
      r_sh_val[upd_row] <= upd_value;
      r_sh_msk[upd_row] <= upd_mask;
    end
  end

  // Every row of the group is rewritten from the shadow on each sweep step.
  for (genvar j = 0; j < GROUP_ROWS; j++) begin : g_row
    logic [c_aw-1:0] w_row;
    assign w_row = c_aw'(int'(r_grp) * GROUP_ROWS + j);
    for (genvar i = 0; i < c_n; i++) begin : g_slice
      slice_rule_t w_sr;
      assign w_sr.valid = r_sh_vld[w_row];
      assign w_sr.value = r_sh_val[w_row][i*KW +: KW];
      assign w_sr.mask  = r_sh_msk[w_row][i*KW +: KW];
      assign w_rules[i*GROUP_ROWS + j] = w_sr.valid & slice_bit(r_cnt, w_sr.value, w_sr.mask);
    end
  end

  // ----------------------------------------------------------- priority encode
  tcam_prio_enc #(
    .D (D)
  ) u_prio_enc (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (r_lk_vld[LOOKUP_LAT]),
    .match     (tcam_match),
    .out_valid (res_valid),
    .out_hit   (res_hit),
    .out_index (res_index)
  );

endmodule

`default_nettype wire

// File: tb/tb_frac_tcam_ctrl.sv
// ============================================================================
// Module      : tb_frac_tcam_ctrl
// Description : Directed bench for frac_tcam_ctrl with a behavioural TCAM array.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_frac_tcam_ctrl;

  localparam int W  = 20;
  localparam int D  = 64;
  localparam int N  = W / 5;
  localparam int NG = D / 8;

  logic            clk;
  logic            rst_n;
  logic            init_done;
  logic            lk_valid;
  logic            lk_ready;
  logic [W-1:0]    lk_key;
  logic            res_valid;
  logic            res_hit;
  logic [5:0]      res_index;
  logic            upd_valid;
  logic            upd_ready;
  logic [5:0]      upd_row;
  logic            upd_en;
  logic [W-1:0]    upd_value;
  logic [W-1:0]    upd_mask;
  logic            upd_done;
  logic [W-1:0]    tcam_sk;
  logic [NG-1:0]   tcam_we;
  logic [N*8-1:0]  tcam_rules;
  logic [D-1:0]    tcam_match;

  int checks = 0;
  int errors = 0;

  frac_tcam_ctrl #(.W(W), .D(D), .LOOKUP_LAT(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .init_done  (init_done),
    .lk_valid   (lk_valid),
    .lk_ready   (lk_ready),
    .lk_key     (lk_key),
    .res_valid  (res_valid),
    .res_hit    (res_hit),
    .res_index  (res_index),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_row    (upd_row),
    .upd_en     (upd_en),
    .upd_value  (upd_value),
    .upd_mask   (upd_mask),
    .upd_done   (upd_done),
    .tcam_sk    (tcam_sk),
    .tcam_we    (tcam_we),
    .tcam_rules (tcam_rules),
    .tcam_match (tcam_match)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Fractured array: one 32 x D LUT per slice, match is the AND across slices.
  logic [D-1:0] lut [N][32];
  initial begin
    for (int i = 0; i < N; i++)
      for (int a = 0; a < 32; a++) lut[i][a] = '1;
  end

  always @(posedge clk) begin
    logic [D-1:0] m;
    m = '1;
    for (int i = 0; i < N; i++) begin
      m &= lut[i][tcam_sk[i*5 +: 5]];
      for (int g = 0; g < NG; g++)
        if (tcam_we[g])
          for (int j = 0; j < 8; j++)
            lut[i][tcam_sk[i*5 +: 5]][g*8 + j] <= tcam_rules[i*8 + j];
    end
    tcam_match <= m;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input logic [7:0] exp_we, input string tag);
    int n_we;
    n_we = 0;
    for (int k = 0; k < 200; k++) begin
      if (upd_done) break;
      if (tcam_we == exp_we) n_we++;
      @(negedge clk);
    end
    chk({tag, "_done"}, upd_done, 1);
    chk({tag, "_we_cycles"}, n_we, 32);
  endtask

  task automatic do_update(input logic [5:0] row, input logic en, input logic [W-1:0] val,
                           input logic [W-1:0] msk, input string tag);
    logic [7:0] exp_we;
    exp_we = 8'd1 << row[5:3];
    @(negedge clk);
    upd_valid = 1'b1; upd_row = row; upd_en = en; upd_value = val; upd_mask = msk;
    #1;
    for (int k = 0; k < 100; k++) begin
      if (upd_ready) break;
      @(negedge clk); #1;
    end
    chk({tag, "_upd_ready"}, upd_ready, 1);
    @(negedge clk);
    upd_valid = 1'b0;
    wait_done(exp_we, tag);
  endtask

  task automatic do_lookup(input logic [W-1:0] key, input logic hit, input logic [5:0] idx,
                           input string tag);
    @(negedge clk);
    lk_valid = 1'b1; lk_key = key;
    #1 chk({tag, "_lk_ready"}, lk_ready, 1);
    @(negedge clk);
    lk_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_early"}, res_valid, 0);
    @(negedge clk);
    chk({tag, "_valid"}, res_valid, 1);
    chk({tag, "_hit"}, res_hit, hit);
    chk({tag, "_index"}, res_index, idx);
  endtask

  initial begin
    logic [4:0]     kk;
    logic [N*8-1:0] exp_rules;
    int             n_lk, n_we;

    rst_n = 1'b0; lk_valid = 1'b0; lk_key = '0; upd_valid = 1'b0;
    upd_row = '0; upd_en = 1'b0; upd_value = '0; upd_mask = '0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_init_done", init_done, 0);
    chk("rst_we", tcam_we, 0);
    chk("rst_rules", tcam_rules, 0);
    chk("rst_sk", tcam_sk, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_upd_done", upd_done, 0);
    chk("rst_readies", {lk_ready, upd_ready}, 0);

    // Both requesters wait through INIT; the update wins the first IDLE cycle.
    lk_valid = 1'b1; lk_key = 20'h0001F;
    upd_valid = 1'b1; upd_row = 6'd5; upd_en = 1'b1; upd_value = 20'h0001F; upd_mask = 20'hFFFFF;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    for (int k = 0; k < 32; k++) begin
      kk = k[4:0];
      chk("init_we", tcam_we, 8'hFF);
      chk("init_sk", tcam_sk, {kk, kk, kk, kk});
      chk("init_rules", tcam_rules, 0);
      chk("init_done_low", init_done, 0);
      chk("init_readies", {lk_ready, upd_ready}, 0);
      @(negedge clk); #1;
    end
    chk("init_done_high", init_done, 1);
    chk("first_idle_upd_ready", upd_ready, 1);
    chk("first_idle_lk_ready", lk_ready, 0);
    chk("first_idle_we", tcam_we, 0);
    lk_valid = 1'b0;
    @(negedge clk);
    upd_valid = 1'b0;

    // Row 5 sweep: slice 0 matches at address 31, slices 1-3 at address 0.
    for (int k = 0; k < 32; k++) begin
      kk = k[4:0];
      exp_rules = '0;
      if (k == 31) exp_rules = exp_rules | 32'h0000_0020;
      if (k == 0)  exp_rules = exp_rules | 32'h2020_2000;
      chk("wr5_we", tcam_we, 8'h01);
      chk("wr5_sk", tcam_sk, {kk, kk, kk, kk});
      chk("wr5_rules", tcam_rules, exp_rules);
      @(negedge clk);
    end
    chk("wr5_done", upd_done, 1);
    chk("wr5_we_off", tcam_we, 0);

    do_lookup(20'h0001F, 1'b1, 6'd5, "hit5");
    do_lookup(20'h0001E, 1'b0, 6'd0, "miss1E");

    do_update(6'd3,  1'b1, 20'h00000, 20'h00000, "wr3");
    do_update(6'd10, 1'b1, 20'h77777, 20'h00000, "wr10");
    do_lookup(20'hABCDE, 1'b1, 6'd3, "prio3");
    do_update(6'd3,  1'b0, 20'h00000, 20'h00000, "inv3");
    do_lookup(20'hABCDE, 1'b1, 6'd10, "prio10");

    do_update(6'd1, 1'b1, 20'h12345, 20'hFFFFF, "wr1");
    do_update(6'd2, 1'b1, 20'h54321, 20'hFFFFF, "wr2");
    do_lookup(20'h12345, 1'b1, 6'd1, "keep1");
    do_lookup(20'h54321, 1'b1, 6'd2, "row2");

    // Alternating grants with a lookup in flight when the update is accepted.
    @(negedge clk);
    lk_valid = 1'b1; lk_key = 20'h12345;
    #1 chk("alt_lk_first", lk_ready, 1);
    @(negedge clk);
    upd_valid = 1'b1; upd_row = 6'd20; upd_en = 1'b1; upd_value = 20'h0F0F0; upd_mask = 20'hFFFFF;
    lk_key = 20'h54321;
    #1;
    chk("alt_upd_ready", upd_ready, 1);
    chk("alt_lk_blocked", lk_ready, 0);
    @(negedge clk);
    upd_row = 6'd21; upd_value = 20'h00FFF;
    #1;
    chk("drain_lk_ready", lk_ready, 0);
    chk("drain_upd_ready", upd_ready, 0);
    chk("drain_we", tcam_we, 0);
    chk("inflight_early", res_valid, 0);
    @(negedge clk);
    chk("inflight_valid", res_valid, 1);
    chk("inflight_hit", res_hit, 1);
    chk("inflight_index", res_index, 1);
    n_lk = 0; n_we = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk); #1;
      if (upd_done) break;
      if (lk_ready) n_lk++;
      if (tcam_we == 8'h04) n_we++;
    end
    chk("wr20_done", upd_done, 1);
    chk("wr20_lk_accepts", n_lk, 0);
    chk("wr20_we_cycles", n_we, 32);
    chk("alt_lk_after_upd", lk_ready, 1);
    chk("alt_upd_held", upd_ready, 0);
    @(negedge clk);
    #1;
    chk("alt_upd_after_lk", upd_ready, 1);
    chk("alt_lk_after_lk", lk_ready, 0);
    lk_valid = 1'b0;
    @(negedge clk);
    upd_valid = 1'b0;
    @(negedge clk);
    chk("alt_res_valid", res_valid, 1);
    chk("alt_res_index", res_index, 2);
    wait_done(8'h04, "wr21");

    do_update(6'd10, 1'b0, 20'h00000, 20'h00000, "inv10");
    do_lookup(20'h0F0F0, 1'b1, 6'd20, "row20");
    do_lookup(20'h00FFF, 1'b1, 6'd21, "row21");

    // Reset in the middle of a write sweep.
    @(negedge clk);
    upd_valid = 1'b1; upd_row = 6'd40; upd_en = 1'b1; upd_value = '0; upd_mask = '0;
    #1 chk("wr40_upd_ready", upd_ready, 1);
    @(negedge clk);
    upd_valid = 1'b0;
    repeat (12) @(negedge clk);
    kk = 5'd12;
    chk("wr40_sk_c12", tcam_sk, {kk, kk, kk, kk});
    chk("wr40_we_c12", tcam_we, 8'h20);
    rst_n = 1'b0;
    #1;
    chk("midrst_we", tcam_we, 0);
    chk("midrst_rules", tcam_rules, 0);
    chk("midrst_sk", tcam_sk, 0);
    chk("midrst_init_done", init_done, 0);
    chk("midrst_readies", {lk_ready, upd_ready}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (init_done) break;
    end
    chk("reinit_done", init_done, 1);
    do_lookup(20'h00000, 1'b0, 6'd0, "post_rst_0");
    do_lookup(20'h12345, 1'b0, 6'd0, "post_rst_12345");
    do_lookup(20'h0F0F0, 1'b0, 6'd0, "post_rst_0F0F0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
